// File: rtl/image_buffer_pkg.sv
// Shared geometry defaults, FSM state encoding and address-width helper
// for the image buffer slice.
package image_pkg;

  localparam int DEF_DATA_W   = 8;
  localparam int DEF_XPIX     = 28;
  localparam int DEF_YPIX     = 28;
  localparam int DEF_CHANNELS = 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  // Address width for an axis of n entries; never narrower than one bit.
  function automatic int axisW(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/image_buffer_if.sv
// Raster load (s_*) and drain (m_*) stream handshakes of the image buffer.
interface image_buffer_if
  import image_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
);

  logic              s_valid;
  logic              s_ready;
  logic [DATA_W-1:0] s_data;
  logic              m_valid;
  logic              m_ready;
  logic [DATA_W-1:0] m_data;
  logic              m_last;

  modport master (
    output s_valid, s_data, m_ready,
    input  s_ready, m_valid, m_data, m_last
  );

  modport slave (
    input  s_valid, s_data, m_ready,
    output s_ready, m_valid, m_data, m_last
  );

endinterface

// File: rtl/image_buffer_raster_counter.sv
// x/y/c raster position counter, x fastest; last flags the final pixel.
module raster_counter
  import image_pkg::*;
#(
  parameter int XPIX     = DEF_XPIX,
  parameter int YPIX     = DEF_YPIX,
  parameter int CHANNELS = DEF_CHANNELS,
  localparam int AXW = axisW(XPIX),
  localparam int AYW = axisW(YPIX),
  localparam int ACW = axisW(CHANNELS)
) (
  input  logic           Clk,
  input  logic           Rst,
  input  logic           clear,
  input  logic           advance,
  output logic [AXW-1:0] x,
  output logic [AYW-1:0] y,
  output logic [ACW-1:0] c,
  output logic           last
);

  localparam logic [AXW-1:0] XMAX = AXW'(XPIX - 1);
  localparam logic [AYW-1:0] YMAX = AYW'(YPIX - 1);
  localparam logic [ACW-1:0] CMAX = ACW'(CHANNELS - 1);

  assign last = (x == XMAX) && (y == YMAX) && (c == CMAX);

  always_ff @(posedge Clk) begin
    if (Rst || clear) begin
      x <= '0;
      y <= '0;
      c <= '0;
    end else if (advance) begin
      if (x == XMAX) begin
        x <= '0;
        if (y == YMAX) begin
          y <= '0;
          c <= (c == CMAX) ? '0 : c + ACW'(1);
        end else begin
          y <= y + AYW'(1);
        end
      end else begin
        x <= x + AXW'(1);
      end
    end
  end

endmodule

// File: rtl/image_buffer.sv
// Frame buffer with random access in IDLE plus raster-order stream load
// and stream drain through a 2-entry skid buffer.
module image_buffer
  import image_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int XPIX     = DEF_XPIX,
  parameter int YPIX     = DEF_YPIX,
  parameter int CHANNELS = DEF_CHANNELS,
  localparam int AXW = axisW(XPIX),
  localparam int AYW = axisW(YPIX),
  localparam int ACW = axisW(CHANNELS)
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              we,
  input  logic              rd,
  input  logic [AXW-1:0]    addr_x,
  input  logic [AYW-1:0]    addr_y,
  input  logic [ACW-1:0]    addr_c,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  output logic              data_out_valid,
  output logic              err,
  input  logic              load_start,
  input  logic              drain_start,
  image_buffer_if.slave     strm,
  output logic              busy,
  output logic              done,
  output logic [47:0]       geom
);

  localparam int DEPTH = XPIX * YPIX * CHANNELS;
  localparam int AW    = axisW(DEPTH);

  localparam logic [AXW:0] XLIM = (AXW + 1)'(XPIX);
  localparam logic [AYW:0] YLIM = (AYW + 1)'(YPIX);
  localparam logic [ACW:0] CLIM = (ACW + 1)'(CHANNELS);

  function automatic logic [AW-1:0] linAddr(input logic [AXW-1:0] ax,
                                            input logic [AYW-1:0] ay,
                                            input logic [ACW-1:0] ac);
    return AW'(ac) * AW'(XPIX * YPIX) + AW'(ay) * AW'(XPIX) + AW'(ax);
  endfunction

  state_t            state;
  logic [DATA_W-1:0] mem [DEPTH];

  logic [AXW-1:0]    rcX;
  logic [AYW-1:0]    rcY;
  logic [ACW-1:0]    rcC;
  logic              rcLast;
  logic [AW-1:0]     rcAddr;
  logic [AW-1:0]     raAddr;
  logic              inRange;
  logic              raWrite;

  logic              sReady;
  logic              loadAccept;
  logic              issue;
  logic              pop;
  logic              issuedAll;
  logic [1:0]        cnt;
  logic              wp;
  logic              rp;
  logic [DATA_W-1:0] fifoData [2];
  logic [1:0]        fifoLast;

  logic              memWe;
  logic [AW-1:0]     memWAddr;
  logic [DATA_W-1:0] memWData;

  assign geom = {16'(CHANNELS), 16'(YPIX), 16'(XPIX)};

  assign rcAddr  = linAddr(rcX, rcY, rcC);
  assign raAddr  = linAddr(addr_x, addr_y, addr_c);
  assign inRange = ({1'b0, addr_x} < XLIM) && ({1'b0, addr_y} < YLIM) &&
                   ({1'b0, addr_c} < CLIM);
  assign raWrite = (state == ST_IDLE) && we && !rd && inRange;

  assign loadAccept = sReady && strm.s_valid;
  // Issue decision depends only on registered occupancy, so m_ready never
  // reaches the memory address; the second entry covers the read latency.
  assign issue = (state == ST_DRAIN) && !issuedAll && (cnt != 2'd2);
  assign pop   = strm.m_valid && strm.m_ready;

  assign strm.s_ready = sReady;
  assign strm.m_valid = (cnt != 2'd0);
  assign strm.m_data  = fifoData[rp];
  assign strm.m_last  = (cnt != 2'd0) && fifoLast[rp];

  always_comb begin
    memWe    = loadAccept || raWrite;
    memWAddr = raAddr;
    memWData = data_in;
    if (loadAccept) begin
      memWAddr = rcAddr;
      memWData = strm.s_data;
    end
  end

  always_ff @(posedge Clk) begin
    if (memWe) mem[memWAddr] <= memWData;
  end

  raster_counter #(
    .XPIX     (XPIX),
    .YPIX     (YPIX),
    .CHANNELS (CHANNELS)
  ) u_raster (
    .Clk     (Clk),
    .Rst     (Rst),
    .clear   ((state == ST_IDLE) && (load_start || drain_start)),
    .advance (loadAccept || issue),
    .x       (rcX),
    .y       (rcY),
    .c       (rcC),
    .last    (rcLast)
  );

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state          <= ST_IDLE;
      busy           <= 1'b0;
      done           <= 1'b0;
      sReady         <= 1'b0;
      data_out       <= '0;
      data_out_valid <= 1'b0;
      err            <= 1'b0;
      issuedAll      <= 1'b0;
      cnt            <= '0;
      wp             <= 1'b0;
      rp             <= 1'b0;
      fifoLast       <= '0;
    end else begin
      done           <= 1'b0;
      data_out_valid <= 1'b0;
      err            <= 1'b0;

      if (we || rd) begin
        if ((we && rd) || !inRange || (state != ST_IDLE)) begin
          err <= 1'b1;
        end else if (rd) begin
          data_out       <= mem[raAddr];
          data_out_valid <= 1'b1;
        end
      end

      if (issue) begin
        fifoData[wp] <= mem[rcAddr];
        fifoLast[wp] <= rcLast;
        wp           <= ~wp;
      end
      if (pop) rp <= ~rp;
      cnt <= cnt + {1'b0, issue} - {1'b0, pop};

      case (state)
        ST_IDLE: begin
          if (load_start) begin
            state  <= ST_LOAD;
            busy   <= 1'b1;
            sReady <= 1'b1;
          end else if (drain_start) begin
            state     <= ST_DRAIN;
            busy      <= 1'b1;
            issuedAll <= 1'b0;
          end
        end
        ST_LOAD: begin
          if (loadAccept && rcLast) begin
            state  <= ST_IDLE;
            busy   <= 1'b0;
            sReady <= 1'b0;
            done   <= 1'b1;
          end
        end
        ST_DRAIN: begin
          if (issue && rcLast) issuedAll <= 1'b1;
          if (pop && strm.m_last) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/image_buffer.md
IMAGE_BUFFER -- requirements
Module: image_buffer

Interface
REQ-001 SHALL have parameter DATA_W, default 8: pixel width in bits.
REQ-002 SHALL have parameter XPIX, default 28: columns per channel.
REQ-003 SHALL have parameter YPIX, default 28: rows per channel.
REQ-004 SHALL have parameter CHANNELS, default 1: channel count; address widths = max(1,$clog2(N)) per axis.
REQ-005 SHALL have port Clk  in  1  sole clock, all logic on posedge.
REQ-006 SHALL have port Rst  in  1  synchronous, active-high reset.
REQ-007 SHALL have port we  in  1  random-access write strobe.
REQ-008 SHALL have port rd  in  1  random-access read strobe.
REQ-009 SHALL have port addr_x  in  AXW  column address.
REQ-010 SHALL have port addr_y  in  AYW  row address.
REQ-011 SHALL have port addr_c  in  ACW  channel address.
REQ-012 SHALL have port data_in  in  DATA_W  random-access write data.
REQ-013 SHALL have port data_out  out  DATA_W  random-access read data.
REQ-014 SHALL have port data_out_valid  out  1  one-cycle pulse qualifying data_out.
REQ-015 SHALL have port err  out  1  one-cycle pulse on rejected random access.
REQ-016 SHALL have port load_start  in  1  begin raster stream fill.
REQ-017 SHALL have port drain_start  in  1  begin raster stream readout.
REQ-018 SHALL have ports s_valid in 1, s_ready out 1, s_data in DATA_W: load stream.
REQ-019 SHALL have ports m_valid out 1, m_ready in 1, m_data out DATA_W: drain stream.
REQ-020 SHALL have port m_last  out  1  marks final drained pixel, qualified by m_valid.
REQ-021 SHALL have port busy  out  1  high while not IDLE.
REQ-022 SHALL have port done  out  1  one-cycle pulse on LOAD/DRAIN completion.
REQ-023 SHALL have port geom  out  48  constant {CHANNELS,YPIX,XPIX}, 16 bits each.

Function
REQ-024 SHALL store XPIX*YPIX*CHANNELS words; raster order x fastest, then y, then c.
REQ-025 SHALL implement FSM IDLE/LOAD/DRAIN; IDLE->LOAD on load_start, IDLE->DRAIN on drain_start; both high: load wins; starts ignored outside IDLE.
REQ-026 SHALL, in IDLE: we&!rd writes data_in next edge; rd&!we gives data_out with data_out_valid exactly 1 cycle later.
REQ-027 SHALL pulse err 1 cycle later, with no write and no data_out_valid, if we&rd, any address out of range, or we/rd asserted while busy.
REQ-028 SHALL in LOAD hold s_ready=1; each s_valid&s_ready writes s_data at the raster counter and advances it.
REQ-029 SHALL on the pixel with linear index XPIX*YPIX*CHANNELS-1 accepted: pulse done next cycle, return to IDLE, s_ready=0.
REQ-030 SHALL in DRAIN assert first m_valid 2 cycles after drain_start, sustain 1 pixel/cycle while m_ready=1, hold m_data/m_last stable while m_valid&!m_ready.
REQ-031 SHALL use an internal 2-entry skid buffer absorbing the 1-cycle read latency; no pixel lost or duplicated under any m_ready pattern.
REQ-032 SHALL pulse done the cycle after the m_last handshake, return to IDLE.
REQ-033 SHALL wrap x to 0 with y+1 at XPIX-1, y to 0 with c+1 at YPIX-1; counters clear on entering LOAD/DRAIN.

Reset
REQ-034 SHALL on Rst: state IDLE, counters 0, skid empty; data_out=0, data_out_valid, err, s_ready, m_valid, m_last, busy, done all 0; memory contents undefined.
REQ-035 SHALL let Rst mid-LOAD/DRAIN abort immediately with no done pulse; in-flight stream data dropped.

Structure
REQ-036 SHALL place default geometry constants and FSM state encoding in shared package image_pkg.
REQ-037 SHALL instantiate one sub-module raster_counter (x/y/c wrap counter with last flag), shared by LOAD and DRAIN.

Verification
REQ-038 SHALL cover: write 0xA5 at (3,4,0), read -> data_out=0xA5, data_out_valid 1 cycle after rd.
REQ-039 SHALL cover: we=rd=1, and rd at addr_x=28 -> err pulse, no write, no data_out_valid.
REQ-040 SHALL cover: load 784 ramp pixels (i mod 256) with random s_valid gaps -> done once; random reads match.
REQ-041 SHALL cover: drain with m_ready=1 -> 784 beats on consecutive cycles, m_last on beat 784 only, data equals ramp.
REQ-042 SHALL cover: drain with random m_ready -> same ordered 784 values, no drops/duplicates, m_data stable while stalled.
REQ-043 SHALL cover: Rst at pixel 400 of LOAD -> all outputs reset next cycle, busy=0, no done.
